// File: rtl/wb_ram_gpio_ctrl.sv
// Wishbone classic RAM slave with a GPIO register block in the top four words,
// a boot loader port, uniform read latency and edge-capture interrupts.
module wb_ram_gpio_ctrl #(
  parameter int                    AW           = 13,
  parameter int                    READ_LATENCY = 1,
  parameter int                    GPIO_OUT_W   = 8,
  parameter int                    GPIO_IN_W    = 2,
  parameter logic [GPIO_OUT_W-1:0] GPIO_RST     = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  input  logic                  ld_stall_i,
  input  logic                  ld_we_i,
  input  logic [AW-1:0]         ld_adr_i,
  input  logic [31:0]           ld_dat_i,
  output logic [31:0]           ld_dat_o,
  output logic [GPIO_OUT_W-1:0] gpio_o,
  input  logic [GPIO_IN_W-1:0]  gpio_i,
  output logic                  irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_RAM  = 2'd1;
  localparam logic [1:0] SRC_REG  = 2'd2;

  state_t                r_state, w_state_next;
  logic [1:0]            r_cnt, w_cnt_next;
  logic                  r_we_q;
  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  w_load_dat;

  logic [31:0]           r_mem [2**AW];
  logic [31:0]           r_ram_q;
  logic [31:0]           r_reg_q;
  logic [1:0]            r_src;

  logic [GPIO_OUT_W-1:0] r_gpio_out;
  logic [GPIO_IN_W-1:0]  r_irq_en, r_pend;
  logic [GPIO_IN_W-1:0]  r_sync1, r_sync2, r_prev;
  logic                  r_irq;

  logic                  w_wb_req, w_wb_commit, w_reg_hit, w_reg_wr;
  logic [AW-1:0]         w_wb_wadr, w_ram_adr;
  logic [1:0]            w_reg_off;
  logic [3:0]            w_ram_sel;
  logic [31:0]           w_ram_dat, w_reg_rd, w_rd0, w_rd;
  logic                  w_ram_we;
  logic [GPIO_OUT_W-1:0] w_out_be;
  logic [GPIO_IN_W-1:0]  w_in_be, w_w1c, w_rise;
  logic                  w_unused_adr;

  assign w_unused_adr = ^{wb_adr_i[31:AW+2], wb_adr_i[1:0]};

  assign w_wb_req    = wb_stb_i & wb_cyc_i;
  assign w_wb_commit = (r_state == S_IDLE) & w_wb_req & ~ld_stall_i;
  assign w_wb_wadr   = wb_adr_i[AW+1:2];
  assign w_reg_hit   = &w_wb_wadr[AW-1:2];
  assign w_reg_off   = w_wb_wadr[1:0];
  assign w_reg_wr    = w_wb_commit & wb_we_i & w_reg_hit;

  // The loader always addresses raw RAM, including the words shadowed by GPIO.
  assign w_ram_adr = ld_stall_i ? ld_adr_i : w_wb_wadr;
  assign w_ram_sel = ld_stall_i ? 4'hF : wb_sel_i;
  assign w_ram_dat = ld_stall_i ? ld_dat_i : wb_dat_i;
  assign w_ram_we  = ld_stall_i ? ld_we_i : (w_wb_commit & wb_we_i & ~w_reg_hit);

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (w_ram_we && w_ram_sel[b]) r_mem[w_ram_adr][8*b +: 8] <= w_ram_dat[8*b +: 8];
    end
    r_ram_q <= r_mem[w_ram_adr];
  end

  for (genvar gi = 0; gi < GPIO_OUT_W; gi++) begin : g_out_be
    assign w_out_be[gi] = wb_sel_i[gi/8];
  end
  for (genvar gi = 0; gi < GPIO_IN_W; gi++) begin : g_in_be
    assign w_in_be[gi] = wb_sel_i[gi/8];
  end

  assign w_w1c  = (w_reg_wr && w_reg_off == 2'd2) ? (wb_dat_i[GPIO_IN_W-1:0] & w_in_be) : '0;
  assign w_rise = r_sync2 & ~r_prev;

  always_comb begin
    w_reg_rd = '0;
    case (w_reg_off)
      2'd0:    w_reg_rd = 32'(r_gpio_out);
      2'd1:    w_reg_rd = 32'(r_sync2);
      2'd2:    w_reg_rd = 32'(r_pend);
      default: w_reg_rd = 32'(r_irq_en);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_gpio_out <= GPIO_RST;
      r_irq_en   <= '0;
      r_pend     <= '0;
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_prev     <= '0;
      r_irq      <= 1'b0;
      r_reg_q    <= '0;
      r_src      <= SRC_NONE;
    end else begin
      if (w_reg_wr && w_reg_off == 2'd0)
        r_gpio_out <= (r_gpio_out & ~w_out_be) | (wb_dat_i[GPIO_OUT_W-1:0] & w_out_be);
      if (w_reg_wr && w_reg_off == 2'd3)
        r_irq_en <= (r_irq_en & ~w_in_be) | (wb_dat_i[GPIO_IN_W-1:0] & w_in_be);
      // A new edge beats a simultaneous clear so no event is ever lost.
      r_pend  <= (r_pend & ~w_w1c) | w_rise;
      r_sync1 <= gpio_i;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_irq   <= |(r_pend & r_irq_en);
      r_reg_q <= w_reg_rd;
      r_src   <= (!ld_stall_i && w_reg_hit) ? SRC_REG : SRC_RAM;
    end
  end

  assign w_rd0 = (r_src == SRC_REG) ? r_reg_q : (r_src == SRC_RAM) ? r_ram_q : '0;

  if (READ_LATENCY > 1) begin : g_pipe
    logic [READ_LATENCY-2:0][31:0] r_pipe;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_pipe <= '0;
      end else begin
        r_pipe[0] <= w_rd0;
        for (int i = 1; i < READ_LATENCY - 1; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign w_rd = r_pipe[READ_LATENCY-2];
  end else begin : g_nopipe
    assign w_rd = w_rd0;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load_dat   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wb_commit) begin
          w_state_next = S_WAIT;
          w_cnt_next   = 2'(READ_LATENCY - 1);
        end
      end
      S_WAIT: begin
        if (!w_wb_req) begin
          w_state_next = S_IDLE;
        end else if (ld_stall_i) begin
          // Reads restart so they return post-load data; writes are already done.
          if (!r_we_q) w_state_next = S_IDLE;
        end else if (r_cnt == 2'd0) begin
          w_state_next = S_ACK;
          w_load_dat   = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      S_ACK: begin
        if (ld_stall_i && r_we_q) begin
          w_state_next = S_WAIT;
          w_cnt_next   = 2'd0;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_we_q  <= 1'b0;
      r_ack   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_wb_commit) r_we_q <= wb_we_i;
      r_ack   <= (w_state_next == S_ACK);
      if (w_load_dat) r_dat <= w_rd;
    end
  end

  // A stall landing on the ack cycle suppresses it; the FSM retries afterwards.
  assign wb_ack_o = r_ack & ~ld_stall_i;
  assign wb_dat_o = r_dat;
  assign ld_dat_o = w_rd;
  assign gpio_o   = r_gpio_out;
  assign irq_o    = r_irq;

endmodule

// File: tb/tb_wb_ram_gpio_ctrl.sv
// Directed bench for wb_ram_gpio_ctrl: a transaction-level model of memory,
// GPIO registers and edge capture is checked every cycle, plus literal expectations.
module tb_wb_ram_gpio_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stb1 = 0, cyc1 = 0, stb3 = 0, cyc3 = 0, we = 0;
  logic [31:0] adr = '0, dat_i = '0;
  logic [3:0]  sel = '0;
  logic        ld_stall = 0, ld_we = 0;
  logic [12:0] ld_adr = '0;
  logic [31:0] ld_dat = '0;
  logic [1:0]  gpio_i = '0;

  logic [31:0] dat_o, ld_dat_o, dat3, ld3;
  logic        ack, irq, ack3, irq3;
  logic [7:0]  gpio_o, gpio3;

  always #5 clk = ~clk;

  wb_ram_gpio_ctrl #(.AW(13), .READ_LATENCY(1)) u_dut (
    .clk_i(clk), .rst_n_i(rst_n), .wb_stb_i(stb1), .wb_cyc_i(cyc1), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .ld_stall_i(ld_stall), .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat),
    .ld_dat_o(ld_dat_o), .gpio_o(gpio_o), .gpio_i(gpio_i), .irq_o(irq));

  wb_ram_gpio_ctrl #(.AW(13), .READ_LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .wb_stb_i(stb3), .wb_cyc_i(cyc3), .wb_adr_i(adr),
    .wb_sel_i(sel), .wb_we_i(we), .wb_dat_i(dat_i), .wb_dat_o(dat3), .wb_ack_o(ack3),
    .ld_stall_i(ld_stall), .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat),
    .ld_dat_o(ld3), .gpio_o(gpio3), .gpio_i(gpio_i), .irq_o(irq3));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  function automatic logic [31:0] bytemask(input logic [3:0] s);
    return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
  endfunction

  // Model state: word-addressed memory, register values, last three gpio samples.
  logic [31:0] mem_m [int];
  logic [7:0]  gpio_m = '0;
  logic [1:0]  en_m = '0, pend_m = '0;
  logic        irq_m = 1'b0;
  logic [1:0]  samp [3] = '{default: 2'b00};
  bit          req_v = 0, req_we = 0;
  logic [31:0] req_adr = '0, req_dat = '0, exp_rd = '0;
  logic [3:0]  req_sel = '0;
  logic [1:0]  m_rise, m_w1c;
  logic [31:0] m_mask;
  int          m_word;
  logic        m_irq_next;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      gpio_m = '0; en_m = '0; pend_m = '0; irq_m = 1'b0; req_v = 0;
      samp = '{default: 2'b00};
    end else begin
      m_rise     = samp[1] & ~samp[2];
      m_w1c      = '0;
      m_irq_next = |(pend_m & en_m);
      if (req_v && !ld_stall) begin
        req_v  = 0;
        m_word = int'(req_adr[14:2]);
        m_mask = bytemask(req_sel);
        if (m_word >= 'h1FFC) begin
          case (m_word - 'h1FFC)
            0: begin
              exp_rd = {24'h0, gpio_m};
              if (req_we) gpio_m = (gpio_m & ~m_mask[7:0]) | (req_dat[7:0] & m_mask[7:0]);
            end
            1: exp_rd = {30'h0, samp[1]};
            2: begin
              exp_rd = {30'h0, pend_m};
              if (req_we) m_w1c = req_dat[1:0] & m_mask[1:0];
            end
            default: begin
              exp_rd = {30'h0, en_m};
              if (req_we) en_m = (en_m & ~m_mask[1:0]) | (req_dat[1:0] & m_mask[1:0]);
            end
          endcase
        end else begin
          exp_rd = mem_m.exists(m_word) ? mem_m[m_word] : 'x;
          if (req_we) mem_m[m_word] = (exp_rd & ~m_mask) | (req_dat & m_mask);
        end
      end
      pend_m = (pend_m & ~m_w1c) | m_rise;
      irq_m  = m_irq_next;
      if (ld_stall && ld_we) mem_m[int'(ld_adr)] = ld_dat;
      samp[2] = samp[1];
      samp[1] = samp[0];
      samp[0] = gpio_i;
    end
  end

  initial begin
    #3;
    forever begin
      @(negedge clk);
      chk("gpio_o_model", {24'h0, gpio_o}, {24'h0, gpio_m});
      chk("irq_o_model", {31'h0, irq}, {31'h0, irq_m});
      if (ld_stall) begin
        chk("ack_during_stall", {31'h0, ack}, 32'h0);
        chk("ack3_during_stall", {31'h0, ack3}, 32'h0);
      end
    end
  end

  // One Wishbone transfer on instance 1 (RL=1) or 3 (RL=3); called at posedge+1.
  task automatic wb(input int which, input bit w, input logic [31:0] a, input logic [3:0] s,
                    input logic [31:0] d, output logic [31:0] rd, output int lat,
                    output logic [31:0] mrd);
    bit got = 0;
    adr = a; sel = s; we = w; dat_i = d;
    if (which == 1) begin
      stb1 = 1; cyc1 = 1;
      req_adr = a; req_sel = s; req_we = w; req_dat = d; req_v = 1;
    end else begin
      stb3 = 1; cyc3 = 1;
    end
    lat = -1; rd = 'x;
    for (int i = 1; i <= 16 && !got; i++) begin
      @(posedge clk); #1;
      if ((which == 1) ? ack : ack3) begin
        got = 1; lat = i; rd = (which == 1) ? dat_o : dat3;
      end
    end
    mrd = exp_rd;
    chk("ack_seen", {31'h0, got}, 32'h1);
    stb1 = 0; cyc1 = 0; stb3 = 0; cyc3 = 0; we = 0;
    @(posedge clk); #1;
    chk("ack_one_cycle", {31'h0, (which == 1) ? ack : ack3}, 32'h0);
    $display("wb%0d %s adr=%08h sel=%h dat=%08h -> rd=%08h lat=%0d", which, w ? "WR" : "RD",
             a, s, d, rd, lat);
  endtask

  logic [31:0] rd, mrd;
  int          lat, cyc_cnt;
  bit          got;

  initial begin
    #2 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    chk("rst_ld_dat_o", ld_dat_o, 32'h0);
    chk("rst_gpio_o", {24'h0, gpio_o}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_ack3", {31'h0, ack3}, 32'h0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    wb(1, 1, 32'h100, 4'hF, 32'hDEADBEEF, rd, lat, mrd);
    chk("wr_lat", lat, 2);
    wb(1, 0, 32'h100, 4'hF, 32'h0, rd, lat, mrd);
    chk("rd_lat", lat, 2);
    chk("rd_model", rd, mrd);
    chk("rd_lit", rd, 32'hDEADBEEF);
    wb(1, 1, 32'h100, 4'b0010, 32'h0000AB00, rd, lat, mrd);
    wb(1, 0, 32'h100, 4'hF, 32'h0, rd, lat, mrd);
    chk("bytewr_model", rd, mrd);
    chk("bytewr_lit", rd, 32'hDEADABEF);

    wb(3, 1, 32'h200, 4'hF, 32'hCAFEF00D, rd, lat, mrd);
    chk("rl3_wr_lat", lat, 4);
    wb(3, 0, 32'h200, 4'hF, 32'h0, rd, lat, mrd);
    chk("rl3_rd_lat", lat, 4);
    chk("rl3_rd_lit", rd, 32'hCAFEF00D);

    ld_stall = 1; ld_we = 1; ld_adr = 13'h1FFC; ld_dat = 32'h11223344;
    @(posedge clk); #1;
    ld_we = 0;
    @(posedge clk); #1;
    chk("ld_rd_lit", ld_dat_o, 32'h11223344);
    chk("ld_rd_model", ld_dat_o, mem_m[32'h1FFC]);
    $display("ld RD adr=1ffc -> %08h", ld_dat_o);
    ld_stall = 0;
    @(posedge clk); #1;

    wb(1, 1, 32'h7FF0, 4'hF, 32'h000000A5, rd, lat, mrd);
    chk("gpio_out_lit", {24'h0, gpio_o}, 32'hA5);
    wb(1, 0, 32'h7FF0, 4'hF, 32'h0, rd, lat, mrd);
    chk("gpio_rd_lit", rd, 32'h000000A5);
    chk("gpio_rd_model", rd, mrd);
    ld_stall = 1; ld_adr = 13'h1FFC;
    @(posedge clk); #1;
    chk("ram_shadow_lit", ld_dat_o, 32'h11223344);
    $display("ld RD adr=1ffc -> %08h", ld_dat_o);
    ld_stall = 0;
    @(posedge clk); #1;

    wb(1, 1, 32'h7FFC, 4'hF, 32'h1, rd, lat, mrd);
    gpio_i = 2'b01;
    repeat (3) begin @(posedge clk); #1; end
    chk("irq_before", {31'h0, irq}, 32'h0);
    @(posedge clk); #1;
    chk("irq_after_edge", {31'h0, irq}, 32'h1);
    $display("edge gpio_i[0] -> irq=%0b", irq);
    wb(1, 0, 32'h7FF8, 4'hF, 32'h0, rd, lat, mrd);
    chk("pend_lit", rd, 32'h1);
    chk("pend_model", rd, mrd);
    wb(1, 0, 32'h7FF4, 4'hF, 32'h0, rd, lat, mrd);
    chk("gpio_in_lit", rd, 32'h1);
    wb(1, 1, 32'h7FF8, 4'hF, 32'h1, rd, lat, mrd);
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    wb(1, 0, 32'h7FF8, 4'hF, 32'h0, rd, lat, mrd);
    chk("pend_cleared", rd, 32'h0);

    gpio_i = 2'b00;
    repeat (4) begin @(posedge clk); #1; end
    gpio_i = 2'b01;
    repeat (2) begin @(posedge clk); #1; end
    wb(1, 1, 32'h7FF8, 4'hF, 32'h1, rd, lat, mrd);
    wb(1, 0, 32'h7FF8, 4'hF, 32'h0, rd, lat, mrd);
    chk("set_wins_lit", rd, 32'h1);
    chk("set_wins_model", rd, mrd);
    chk("set_wins_irq", {31'h0, irq}, 32'h1);

    wb(1, 1, 32'h300, 4'hF, 32'hAAAA5555, rd, lat, mrd);
    adr = 32'h300; sel = 4'hF; we = 0; stb1 = 1; cyc1 = 1;
    @(posedge clk); #1;
    ld_stall = 1; ld_we = 1; ld_adr = 13'h0C0; ld_dat = 32'h12345678;
    @(posedge clk); #1;
    ld_we = 0;
    repeat (2) begin @(posedge clk); #1; end
    ld_stall = 0;
    got = 0; cyc_cnt = 0;
    for (int i = 1; i <= 16 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1; cyc_cnt = i; rd = dat_o; end
    end
    chk("stall_ack_seen", {31'h0, got}, 32'h1);
    chk("stall_ack_lat", cyc_cnt, 2);
    chk("stall_rd_lit", rd, 32'h12345678);
    chk("stall_rd_model", rd, mem_m[32'h0C0]);
    $display("stall RD adr=00000300 -> rd=%08h after %0d cycles", rd, cyc_cnt);
    stb1 = 0; cyc1 = 0;
    @(posedge clk); #1;

    adr = 32'h100; sel = 4'hF; we = 0; stb1 = 1; cyc1 = 1;
    @(posedge clk); #1;
    rst_n = 0; stb1 = 0; cyc1 = 0;
    #1;
    chk("midrst_ack", {31'h0, ack}, 32'h0);
    chk("midrst_gpio", {24'h0, gpio_o}, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    $display("reset mid-WAIT -> ack=%0b gpio=%02h irq=%0b", ack, gpio_o, irq);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    wb(1, 0, 32'h100, 4'hF, 32'h0, rd, lat, mrd);
    chk("postrst_lat", lat, 2);
    chk("postrst_ram_kept", rd, 32'hDEADABEF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
